// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset main control FSM.
package riscv_ctrl_pkg;

  // Main controller states
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } ctrl_state_e;

  // Supported opcodes (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // alu_op encodings
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // alu_src_a encodings
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  // result_src encodings
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU_RES  = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I-subset core (lw, sw, R-type, beq, addi, jal).
module multicycle_main_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_instr
);

  ctrl_state_e state_q, state_d;

  // State register; reset lands directly in fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; memory states hold until mem_ready
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecuteR;
          OP_ITYPE:     state_d = StExecuteI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StFetch;
      default:    state_d = StFetch;  // unreachable encodings recover
    endcase
  end

  // Output decode from state, with mem_ready/zero qualifying the PC and IR loads
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    alu_op        = ALU_OP_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      StDecode: begin
        // Precompute the branch target into the ALU out register
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal_instr = 1'b0;
          default:                                          illegal_instr = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = RES_MEM_DATA;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      StExecuteI: begin
        // addi is the only I-type op supported, so force add
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      StAluWb: begin
        reg_write = 1'b1;
      end
      StBeq: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_SUB;
        pc_write  = zero;
      end
      StJal: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Enables and the illegal pulse are suppressed while reset is held
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle output vectors checked against constants.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;

  int n_pass  = 0;
  int n_total = 0;

  multicycle_main_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .alu_op       (alu_op),
    .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: mem_req mem_write adr_src ir_write pc_write reg_write |
  //              alu_src_a alu_src_b result_src alu_op | illegal_instr
  logic [14:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};

  localparam logic [14:0] V_RESET    = 15'b000000_00_10_10_00_0;
  localparam logic [14:0] V_FETCH_R  = 15'b100110_00_10_10_00_0;
  localparam logic [14:0] V_FETCH_NR = 15'b100000_00_10_10_00_0;
  localparam logic [14:0] V_DECODE   = 15'b000000_01_01_00_00_0;
  localparam logic [14:0] V_DEC_ILL  = 15'b000000_01_01_00_00_1;
  localparam logic [14:0] V_MEMADR   = 15'b000000_10_01_00_00_0;
  localparam logic [14:0] V_MEMREAD  = 15'b101000_00_00_00_00_0;
  localparam logic [14:0] V_MEMWB    = 15'b000001_00_00_01_00_0;
  localparam logic [14:0] V_MEMWRITE = 15'b111000_00_00_00_00_0;
  localparam logic [14:0] V_EXEC_R   = 15'b000000_10_00_00_10_0;
  localparam logic [14:0] V_EXEC_I   = 15'b000000_10_01_00_00_0;
  localparam logic [14:0] V_ALUWB    = 15'b000001_00_00_00_00_0;
  localparam logic [14:0] V_BEQ_T    = 15'b000010_10_00_00_01_0;
  localparam logic [14:0] V_BEQ_NT   = 15'b000000_10_00_00_01_0;
  localparam logic [14:0] V_JAL      = 15'b000010_01_10_00_00_0;

  // Settle, compare, then advance to 1 time unit after the next rising edge
  task automatic cyc(input string tag, input logic [14:0] expv);
    #2;
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op        = 7'b0000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    n_total++;
    assert (obs === V_RESET) n_pass++;
    else $error("FAIL reset observed=%b expected=%b", obs, V_RESET);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fetch stall, then lw with mem_ready=1
    op = 7'b0000011;
    mem_ready = 1'b0;
    cyc("fetch_stall", V_FETCH_NR);
    mem_ready = 1'b1;
    cyc("lw_fetch", V_FETCH_R);
    cyc("lw_decode", V_DECODE);
    cyc("lw_memadr", V_MEMADR);
    cyc("lw_memread", V_MEMREAD);
    cyc("lw_memwb", V_MEMWB);

    // sw with three wait cycles in MEMWRITE; mem_ready low in decode is ignored
    op = 7'b0100011;
    cyc("sw_fetch", V_FETCH_R);
    mem_ready = 1'b0;
    cyc("sw_decode", V_DECODE);
    cyc("sw_memadr", V_MEMADR);
    cyc("sw_wait0", V_MEMWRITE);
    cyc("sw_wait1", V_MEMWRITE);
    cyc("sw_wait2", V_MEMWRITE);
    mem_ready = 1'b1;
    cyc("sw_done", V_MEMWRITE);

    // beq taken
    op = 7'b1100011;
    zero = 1'b1;
    cyc("beq_t_fetch", V_FETCH_R);
    cyc("beq_t_decode", V_DECODE);
    cyc("beq_t_beq", V_BEQ_T);

    // beq not taken
    zero = 1'b0;
    cyc("beq_nt_fetch", V_FETCH_R);
    cyc("beq_nt_decode", V_DECODE);
    cyc("beq_nt_beq", V_BEQ_NT);

    // R-type
    op = 7'b0110011;
    cyc("r_fetch", V_FETCH_R);
    cyc("r_decode", V_DECODE);
    cyc("r_exec", V_EXEC_R);
    cyc("r_aluwb", V_ALUWB);

    // addi
    op = 7'b0010011;
    cyc("i_fetch", V_FETCH_R);
    cyc("i_decode", V_DECODE);
    cyc("i_exec", V_EXEC_I);
    cyc("i_aluwb", V_ALUWB);

    // jal
    op = 7'b1101111;
    cyc("jal_fetch", V_FETCH_R);
    cyc("jal_decode", V_DECODE);
    cyc("jal_jal", V_JAL);

    // illegal opcode: pulse in decode only, straight back to fetch
    op = 7'b0000000;
    cyc("ill_fetch", V_FETCH_R);
    cyc("ill_decode", V_DEC_ILL);
    op = 7'b0000011;
    cyc("ill_next_fetch", V_FETCH_R);

    // reset during a stalled MEMREAD (lw fetch above already consumed)
    cyc("rst_decode", V_DECODE);
    cyc("rst_memadr", V_MEMADR);
    mem_ready = 1'b0;
    cyc("rst_memread", V_MEMREAD);
    rst_n = 1'b0;
    #2;
    n_total++;
    assert (obs === V_RESET) n_pass++;
    else $error("FAIL rst_mid_access observed=%b expected=%b", obs, V_RESET);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post_rst_fetch_stall", V_FETCH_NR);
    mem_ready = 1'b1;
    cyc("post_rst_fetch", V_FETCH_R);
    cyc("post_rst_decode", V_DECODE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
